oled_serial_target: RTL and testbench



---
 rtl/oled_serial_target.sv | 208 ++++++++++++++++++++
 tb/tb_oled_serial_target.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/oled_serial_target.sv
// I2C write-only target standing in for the serial OLED display.
// Matches the display address, ACKs each byte, decodes the control byte
// and emits command strobes or framebuffer writes with an auto-incrementing
// pointer that survives across transactions.
module oled_serial_target #(
  parameter logic [6:0] TARGET_ADDR   = 7'h3c,
  parameter int         SCREEN_WIDTH  = 128,
  parameter int         SCREEN_HEIGHT = 64,
  parameter int         FB_BYTES      = SCREEN_WIDTH * SCREEN_HEIGHT / 8,
  parameter int         ADDR_BITS     = (FB_BYTES > 1) ? $clog2(FB_BYTES) : 1
) (
  input  logic                 in_clk,
  input  logic                 in_rst,
  input  logic                 in_serial_clk,
  inout  wire                  inout_serial,
  output logic                 out_busy,
  output logic [7:0]           out_cmd,
  output logic                 out_cmd_valid,
  output logic [7:0]           out_data,
  output logic [ADDR_BITS-1:0] out_data_addr,
  output logic                 out_data_valid
);

  localparam logic [ADDR_BITS-1:0] PTR_LAST = ADDR_BITS'(FB_BYTES - 1);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, CTRL, CTRL_ACK, BYTE, BYTE_ACK, IGNORE
  } state_e;

  logic scl_s1_q, scl_s2_q, scl_prev_q;
  logic sda_s1_q, sda_s2_q, sda_prev_q;

  state_e                 state_q, state_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic [7:0]             shift_q, shift_d;
  logic                   ack_drv_q, ack_drv_d;
  logic                   sda_oe_q, sda_oe_d;
  logic                   busy_q, busy_d;
  logic                   co_q, co_d;
  logic                   dc_q, dc_d;
  logic [ADDR_BITS-1:0]   ptr_q, ptr_d;
  logic [7:0]             cmd_q, cmd_d;
  logic                   cmd_valid_q, cmd_valid_d;
  logic [7:0]             data_q, data_d;
  logic [ADDR_BITS-1:0]   data_addr_q, data_addr_d;
  logic                   data_valid_q, data_valid_d;

  logic scl_rise, scl_fall, start_det, stop_det;

  // Two-flop synchronisers plus previous-value registers; reset to the idle-high bus level.
  always_ff @(posedge in_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (in_rst) begin
      scl_s1_q   <= 1'b1;
      scl_s2_q   <= 1'b1;
      scl_prev_q <= 1'b1;
      sda_s1_q   <= 1'b1;
      sda_s2_q   <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_s1_q   <= in_serial_clk;
      scl_s2_q   <= scl_s1_q;
      scl_prev_q <= scl_s2_q;
      sda_s1_q   <= inout_serial;
      sda_s2_q   <= sda_s1_q;
      sda_prev_q <= sda_s2_q;
    end
  end

  assign scl_rise  =  scl_s2_q & ~scl_prev_q;
  assign scl_fall  = ~scl_s2_q &  scl_prev_q;
  assign start_det =  scl_s2_q &  scl_prev_q &  sda_prev_q & ~sda_s2_q;
  assign stop_det  =  scl_s2_q &  scl_prev_q & ~sda_prev_q &  sda_s2_q;

  // State and datapath registers.
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      ack_drv_q    <= 1'b0;
      sda_oe_q     <= 1'b0;
      busy_q       <= 1'b0;
      co_q         <= 1'b0;
      dc_q         <= 1'b0;
      ptr_q        <= '0;
      cmd_q        <= '0;
      cmd_valid_q  <= 1'b0;
      data_q       <= '0;
      data_addr_q  <= '0;
      data_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      ack_drv_q    <= ack_drv_d;
      sda_oe_q     <= sda_oe_d;
      busy_q       <= busy_d;
      co_q         <= co_d;
      dc_q         <= dc_d;
      ptr_q        <= ptr_d;
      cmd_q        <= cmd_d;
      cmd_valid_q  <= cmd_valid_d;
      data_q       <= data_d;
      data_addr_q  <= data_addr_d;
      data_valid_q <= data_valid_d;
    end
  end

  // Bus protocol FSM: byte shifting, ACK slot timing, control decode and strobes.
  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    ack_drv_d    = ack_drv_q;
    sda_oe_d     = sda_oe_q;
    busy_d       = busy_q;
    co_d         = co_q;
    dc_d         = dc_q;
    ptr_d        = ptr_q;
    cmd_d        = cmd_q;
    cmd_valid_d  = 1'b0;
    data_d       = data_q;
    data_addr_d  = data_addr_q;
    data_valid_d = 1'b0;

    // Pointer advances the cycle after a data strobe, wrapping at the framebuffer end.
    if (data_valid_q) begin
      ptr_d = (ptr_q == PTR_LAST) ? '0 : ptr_q + 1'b1;
    end

    if (stop_det || start_det) begin
      state_d   = stop_det ? IDLE : ADDR;
      busy_d    = 1'b0;
      sda_oe_d  = 1'b0;
      ack_drv_d = 1'b0;
      bit_cnt_d = '0;
    end else begin
      unique case (state_q)
        ADDR, CTRL, BYTE: begin
          if (scl_rise) begin
            shift_d   = {shift_q[6:0], sda_s2_q};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              ack_drv_d = 1'b0;
              if (state_q == ADDR) begin
                if (shift_d[7:1] == TARGET_ADDR && !shift_d[0]) begin
                  state_d = ADDR_ACK;
                  busy_d  = 1'b1;
                end else begin
                  state_d = IGNORE;
                end
              end else if (state_q == CTRL) begin
                co_d    = shift_d[7];
                dc_d    = shift_d[6];
                state_d = CTRL_ACK;
              end else begin
                state_d = BYTE_ACK;
                if (!dc_q) begin
                  cmd_d       = shift_d;
                  cmd_valid_d = 1'b1;
                  if (shift_d == 8'h21) begin
                    ptr_d = '0;
                  end
                end else begin
                  data_d       = shift_d;
                  data_addr_d  = ptr_q;
                  data_valid_d = 1'b1;
                end
              end
            end
          end
        end
        ADDR_ACK, CTRL_ACK, BYTE_ACK: begin
          // First SCL fall starts driving the ACK, the second one ends the slot.
          if (scl_fall) begin
            if (!ack_drv_q) begin
              sda_oe_d  = 1'b1;
              ack_drv_d = 1'b1;
            end else begin
              sda_oe_d  = 1'b0;
              ack_drv_d = 1'b0;
              bit_cnt_d = '0;
              if (state_q == ADDR_ACK)      state_d = CTRL;
              else if (state_q == CTRL_ACK) state_d = BYTE;
              else                          state_d = co_q ? CTRL : BYTE;
            end
          end
        end
        IDLE, IGNORE: begin
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Open-drain SDA; reset releases the line combinationally in the same cycle.
  assign inout_serial = (sda_oe_q && !in_rst) ? 1'b0 : 1'bz;

  assign out_busy       = busy_q;
  assign out_cmd        = cmd_q;
  assign out_cmd_valid  = cmd_valid_q;
  assign out_data       = data_q;
  assign out_data_addr  = data_addr_q;
  assign out_data_valid = data_valid_q;

endmodule

// File: tb/tb_oled_serial_target.sv
// Bench for oled_serial_target: a bit-banged I2C master plus a strobe scoreboard.
`timescale 1ns/1ps
module tb_oled_serial_target;

  localparam int QTR = 625;  // quarter of a 400 kHz SCL period

  logic       clk = 1'b0;
  logic       rst;
  logic       scl;
  logic       master_low;
  wire        sda;
  logic       busy;
  logic [7:0] cmd;
  logic       cmd_valid;
  logic [7:0] data;
  logic [1:0] data_addr;
  logic       data_valid;

  int checks      = 0;
  int failures    = 0;
  int dut_low_cnt = 0;
  int ptr_m       = 0;

  typedef struct {
    bit         is_data;
    logic [7:0] val;
    logic [1:0] addr;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  assign sda = master_low ? 1'b0 : 1'bz;
  pullup (sda);

  oled_serial_target #(
    .TARGET_ADDR  (7'h3c),
    .SCREEN_WIDTH (4),
    .SCREEN_HEIGHT(8)
  ) dut (
    .in_clk        (clk),
    .in_rst        (rst),
    .in_serial_clk (scl),
    .inout_serial  (sda),
    .out_busy      (busy),
    .out_cmd       (cmd),
    .out_cmd_valid (cmd_valid),
    .out_data      (data),
    .out_data_addr (data_addr),
    .out_data_valid(data_valid)
  );

  always #50 clk = ~clk;  // 10 MHz

  // Cycles where the target is the one holding SDA low.
  always @(negedge clk) begin
    if (!master_low && sda === 1'b0) dut_low_cnt++;
  end

  // Scoreboard: every strobe pops and compares one expectation.
  always @(negedge clk) begin
    if (!rst && (cmd_valid || data_valid)) begin
      checks++;
      if (cmd_valid && data_valid) begin
        failures++;
        $display("FAIL strobe_overlap cmd_valid=%0b data_valid=%0b required=exclusive", cmd_valid, data_valid);
      end else if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_strobe cmd=%02h data=%02h addr=%0d is_data=%0b required=none", cmd, data, data_addr, data_valid);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_e.is_data !== data_valid ||
            (!mon_e.is_data && cmd !== mon_e.val) ||
            (mon_e.is_data && (data !== mon_e.val || data_addr !== mon_e.addr))) begin
          failures++;
          $display("FAIL strobe got is_data=%0b cmd=%02h data=%02h addr=%0d required is_data=%0b val=%02h addr=%0d",
                   data_valid, cmd, data, data_addr, mon_e.is_data, mon_e.val, mon_e.addr);
        end
      end
    end
  end

  task automatic expect_cmd(input logic [7:0] b);
    exp_t e;
    e.is_data = 1'b0; e.val = b; e.addr = 2'd0;
    exp_q.push_back(e);
    if (b == 8'h21) ptr_m = 0;
  endtask

  task automatic expect_data(input logic [7:0] b);
    exp_t e;
    e.is_data = 1'b1; e.val = b; e.addr = 2'(ptr_m);
    exp_q.push_back(e);
    ptr_m = (ptr_m + 1) % 4;
  endtask

  task automatic send_bit(input logic b);
    master_low = !b;
    #QTR; scl = 1'b1;
    #(2*QTR); scl = 1'b0;
    #QTR;
  endtask

  task automatic get_ack(output logic ack);
    master_low = 1'b0;
    #QTR; scl = 1'b1;
    #QTR; ack = (sda === 1'b0);
    #QTR; scl = 1'b0;
    #QTR;
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    get_ack(ack);
  endtask

  task automatic bus_start();
    master_low = 1'b0; scl = 1'b1;
    #QTR; master_low = 1'b1;
    #QTR; scl = 1'b0;
    #QTR;
  endtask

  task automatic bus_stop();
    master_low = 1'b1;
    #QTR; scl = 1'b1;
    #QTR; master_low = 1'b0;
    #(2*QTR);
  endtask

  task automatic test_reset();
    rst = 1'b1; scl = 1'b1; master_low = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, cmd, cmd_valid, data, data_addr, data_valid} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got busy=%0b cmd=%02h cv=%0b data=%02h addr=%0d dv=%0b required all 0",
               busy, cmd, cmd_valid, data, data_addr, data_valid);
    end
    checks++;
    if (sda !== 1'b1) begin
      failures++;
      $display("FAIL reset_sda got=%0b required=1 (released)", sda);
    end
    rst = 1'b0;
    repeat (4) @(negedge clk);
    #3;
  endtask

  task automatic test_cmd();
    logic a;
    logic [7:0] bytes [3] = '{8'h78, 8'h00, 8'hAF};
    bus_start();
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL cmd_busy_pre got=%0b required=0", busy); end
    for (int i = 0; i < 3; i++) begin
      if (i == 2) expect_cmd(bytes[i]);
      send_byte(bytes[i], a);
      checks++;
      if (a !== 1'b1) begin failures++; $display("FAIL cmd_ack%0d got=%0b required=1", i, a); end
      checks++;
      if (busy !== 1'b1) begin failures++; $display("FAIL cmd_busy%0d got=%0b required=1", i, busy); end
    end
    bus_stop();
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL cmd_busy_stop got=%0b required=0", busy); end
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL cmd_missing got=%0d pending required=0", exp_q.size()); end
  endtask

  task automatic test_data();
    logic a;
    int acks = 0;
    bus_start();
    send_byte(8'h78, a); acks += int'(a);
    send_byte(8'h40, a); acks += int'(a);
    expect_data(8'hC3);
    send_byte(8'hC3, a); acks += int'(a);
    expect_data(8'h3C);
    send_byte(8'h3C, a); acks += int'(a);
    bus_stop();
    checks++;
    if (acks != 4) begin failures++; $display("FAIL data_acks got=%0d required=4", acks); end
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL data_missing got=%0d pending required=0", exp_q.size()); end
  endtask

  task automatic test_ignore();
    logic a;
    int low0;
    logic [7:0] addrs [2] = '{8'h7A, 8'h79};
    low0 = dut_low_cnt;
    for (int t = 0; t < 2; t++) begin
      bus_start();
      send_byte(addrs[t], a);
      checks++;
      if (a !== 1'b0) begin failures++; $display("FAIL ignore_addr_ack%0d got=%0b required=0", t, a); end
      for (int i = 0; i < 3; i++) begin
        send_byte(8'h40 + 8'(i), a);
        checks++;
        if (a !== 1'b0 || busy !== 1'b0) begin
          failures++;
          $display("FAIL ignore_byte%0d_%0d ack=%0b busy=%0b required 0/0", t, i, a, busy);
        end
      end
      bus_stop();
    end
    checks++;
    if (dut_low_cnt != low0) begin failures++; $display("FAIL ignore_sda_driven got=%0d cycles required=0", dut_low_cnt - low0); end
  endtask

  task automatic test_wrap();
    logic a;
    int acks = 0;
    bus_start();
    send_byte(8'h78, a); acks += int'(a);
    send_byte(8'h40, a); acks += int'(a);
    for (int i = 0; i < 6; i++) begin
      expect_data(8'h10 + 8'(i));
      send_byte(8'h10 + 8'(i), a); acks += int'(a);
    end
    bus_stop();
    bus_start();
    send_byte(8'h78, a); acks += int'(a);
    send_byte(8'h00, a); acks += int'(a);
    expect_cmd(8'h21);
    send_byte(8'h21, a); acks += int'(a);
    bus_stop();
    bus_start();
    send_byte(8'h78, a); acks += int'(a);
    send_byte(8'h40, a); acks += int'(a);
    expect_data(8'h55);
    send_byte(8'h55, a); acks += int'(a);
    bus_stop();
    checks++;
    if (acks != 14) begin failures++; $display("FAIL wrap_acks got=%0d required=14", acks); end
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL wrap_missing got=%0d pending required=0", exp_q.size()); end
  endtask

  task automatic test_co_stream();
    logic a;
    int low0;
    bus_start();
    send_byte(8'h78, a);
    send_byte(8'h80, a);
    expect_cmd(8'hA5);
    send_byte(8'hA5, a);
    send_byte(8'h40, a);
    expect_data(8'h11);
    send_byte(8'h11, a);
    checks++;
    if (a !== 1'b1) begin failures++; $display("FAIL co_last_ack got=%0b required=1", a); end
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    bus_stop();
    checks++;
    if (busy !== 1'b0 || sda !== 1'b1) begin
      failures++;
      $display("FAIL co_partial_stop busy=%0b sda=%0b required 0/1", busy, sda);
    end
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL co_missing got=%0d pending required=0", exp_q.size()); end
    // Idle target must not respond to a byte without a START.
    low0 = dut_low_cnt;
    send_byte(8'h78, a);
    bus_stop();
    checks++;
    if (a !== 1'b0 || dut_low_cnt != low0) begin
      failures++;
      $display("FAIL co_idle_after_stop ack=%0b low_cycles=%0d required 0/0", a, dut_low_cnt - low0);
    end
  endtask

  task automatic test_reset_midtransfer();
    logic a;
    int low0;
    bus_start();
    send_byte(8'h78, a);
    send_byte(8'h40, a);
    expect_data(8'h66);
    for (int i = 7; i >= 0; i--) send_bit(8'h66 >> i);
    master_low = 1'b0;
    #QTR; scl = 1'b1;
    #QTR;
    checks++;
    if (sda !== 1'b0) begin failures++; $display("FAIL rst_ack_driven got=%0b required=0", sda); end
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL rst_strobe_missing got=%0d pending required=0", exp_q.size()); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (sda !== 1'b1) begin failures++; $display("FAIL rst_sda_same_cycle got=%0b required=1", sda); end
    @(negedge clk);
    checks++;
    if ({busy, cmd, cmd_valid, data, data_addr, data_valid} !== '0) begin
      failures++;
      $display("FAIL rst_mid_outputs got busy=%0b cmd=%02h cv=%0b data=%02h addr=%0d dv=%0b required all 0",
               busy, cmd, cmd_valid, data, data_addr, data_valid);
    end
    rst = 1'b0;
    ptr_m = 0;
    #3;
    #QTR; scl = 1'b0;
    #QTR;
    low0 = dut_low_cnt;
    send_byte(8'hAA, a);
    checks++;
    if (a !== 1'b0 || dut_low_cnt != low0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL rst_rest_ignored ack=%0b low_cycles=%0d busy=%0b required 0/0/0", a, dut_low_cnt - low0, busy);
    end
    bus_stop();
    bus_start();
    send_byte(8'h78, a);
    send_byte(8'h40, a);
    expect_data(8'h99);
    send_byte(8'h99, a);
    bus_stop();
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL rst_after_missing got=%0d pending required=0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_cmd();
    test_data();
    test_ignore();
    test_wrap();
    test_co_stream();
    test_reset_midtransfer();
    repeat (10) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
